// File: rtl/rr_mux_arbiter_if.sv
`timescale 1ns/1ps
// rr_mux_arbiter_if: handshake bundle for the N_CH-to-1 arbitrated mux.
//   req_valid/req_data/req_ready : per-channel request side (channel i at [i*W +: W])
//   out_valid/out_data/out_ch    : registered output beat and its source channel
//   out_ready                    : downstream accept
// Modports: master = requesters plus downstream consumer, slave = the arbiter.
interface rr_mux_arbiter_if #(
  parameter int N_CH = 2,
  parameter int W    = 32
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]   req_valid;
  logic [N_CH*W-1:0] req_data;
  logic [N_CH-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [CW-1:0]     out_ch;
  logic              out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
`timescale 1ns/1ps
// rr_mux_arbiter: registered N_CH-to-1 mux with valid/ready handshakes and
// round-robin (FIXED_PRIO=0) or fixed-priority (FIXED_PRIO=1, channel 0 highest)
// arbitration, followed by a one-entry output register.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of rr_mux_arbiter_if (req_valid/req_data/req_ready,
//           out_valid/out_data/out_ch/out_ready)
module rr_mux_arbiter #(
  parameter int N_CH       = 2,
  parameter int W          = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_mux_arbiter_if.slave bus
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW:0] NCH_L = N_CH[CW:0];

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   base_p0;
  logic            grant_vld_p0;
  logic [CW-1:0]   grant_ch_p0;
  logic            can_load_p0;
  logic            xfer_p0;
  logic [N_CH-1:0] ready_p0;
  logic [W-1:0]    data_p1;
  logic [CW-1:0]   ch_p1;

  // (a + b) mod N_CH for operands already below N_CH.
  function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NCH_L) s = s - NCH_L;
    return s[CW-1:0];
  endfunction

  // ---- Stage p0: arbitration and request-side handshake ----
  always_comb begin
    base_p0      = (FIXED_PRIO != 0) ? '0 : ptr;
    grant_vld_p0 = 1'b0;
    grant_ch_p0  = '0;
    // Scan from the farthest candidate back towards base so the nearest valid
    // channel in rotation order is the last one written and therefore wins.
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_add(base_p0, CW'(k))]) begin
        grant_vld_p0 = 1'b1;
        grant_ch_p0  = wrap_add(base_p0, CW'(k));
      end
    end
  end

  always_comb begin
    // rst_n gates the accept so no requester sees a handshake during reset.
    can_load_p0 = rst_n & ((state == EMPTY) | bus.out_ready);
    xfer_p0     = can_load_p0 & grant_vld_p0;
    ready_p0    = '0;
    if (xfer_p0) ready_p0[grant_ch_p0] = 1'b1;
  end

  assign bus.req_ready = ready_p0;

  // Output-register occupancy: EMPTY/FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (xfer_p0) state_nxt = FULL;
      FULL:  if (bus.out_ready && !xfer_p0) state_nxt = EMPTY;
    endcase
  end

  // ---- Stage p1: output register and rotation pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      ch_p1   <= '0;
      ptr     <= '0;
    end else if (xfer_p0) begin
      data_p1 <= bus.req_data[grant_ch_p0*W +: W];
      ch_p1   <= grant_ch_p0;
      // Fixed priority never rotates, so ptr stays at its reset value there.
      if (FIXED_PRIO == 0) ptr <= wrap_add(grant_ch_p0, CW'(1));
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_p1;
  assign bus.out_ch    = ch_p1;
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Parametrised, registered N-to-1 multiplexer with valid/ready handshakes and round-robin or fixed-priority arbitration. It generalises the datapath 2:1 select into a W-bit, N-channel arbitrated mux with a one-entry output register. It sits in front of the single-ported memory, merging instruction-fetch and load/store requests, and is reusable for any shared-port merge.

## Interface
- N_CH, 2, number of input channels (2..8)
- W, 32, payload width in bits
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority, channel 0 highest
- CW, $clog2(N_CH) (min 1), channel-index width (derived, not overridden)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  N_CH  per-channel request valid
- req_data  in  N_CH*W  per-channel payload; channel i at bits [i*W +: W]
- req_ready  out  N_CH  per-channel accept; one-hot or zero
- out_valid  out  1  output register holds a beat
- out_data  out  W  registered payload
- out_ch  out  CW  index of the channel that produced out_data
- out_ready  in  1  downstream accept

## Operation
- Output register states:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- can_load = !out_valid | out_ready.
- Grant selection (combinational):
  - FIXED_PRIO=1: lowest-index channel with req_valid=1.
  - FIXED_PRIO=0: first channel with req_valid=1, searching ptr, ptr+1, …, N_CH-1, 0, …, ptr-1 (modulo N_CH).
  - At most one grant per cycle.
- req_ready[g] = can_load & req_valid[g] for granted channel g; all other bits 0.
- Transfer on channel g when req_valid[g] & req_ready[g]. At the next edge:
  - out_data <= req_data[g]
  - out_ch <= g
  - out_valid <= 1
- Round-robin pointer (FIXED_PRIO=0 only):
  - On a transfer: ptr <= (g+1) mod N_CH.
  - Otherwise ptr holds.
  - With FIXED_PRIO=1, ptr is unused and stays 0.
- Drain: out_ready & out_valid with no new transfer sets out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load: the register reloads and out_valid stays 1. This is the full-throughput case.
- FULL & !out_ready: all req_ready = 0. out_data, out_ch and ptr hold.
- Requester rules:
  - Once req_valid[i]=1, the requester holds it and req_data[i] stable until req_ready[i]=1.
  - The block does not rely on this rule; grant is re-evaluated every cycle.
- Reset (asynchronous, rst_n=0) clears: out_valid=0, out_data=0, out_ch=0, ptr=0.
  - req_ready is 0 while in reset.
  - Reset mid-transfer discards the held beat. No partial state survives.

## Timing
- Latency: request accepted at edge k appears on out_* after edge k, i.e. 1 cycle.
- Throughput: 1 beat/cycle while out_ready=1.
- req_ready is combinational from req_valid, out_valid, out_ready and ptr. There is no combinational path from req_data to any output.
- out_valid, out_data and out_ch are registers only. No combinational path from inputs.
- Fairness: with all N_CH channels continuously valid and out_ready=1, each channel is granted exactly once every N_CH cycles, in index order.
- Release of rst_n is synchronous to clk by the system. The first grant can occur on the first edge after release.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 mid-stream with out_valid=1.
  - Required response: out_valid=0, out_data=0, out_ch=0 immediately, without waiting for a clock edge.
  - After release, with both channels valid, the first grant goes to channel 0.
- Single channel, N_CH=2, W=32:
  - Stimulus: ch1 valid, data 0xDEADBEEF, out_ready=1.
  - Required response: req_ready=2'b10; next cycle out_valid=1, out_data=0xDEADBEEF, out_ch=1.
- Round-robin contention, N_CH=4:
  - Stimulus: all channels valid, data 0x10+i, out_ready=1.
  - Required response: out_ch sequence 0,1,2,3,0,1… and out_data 0x10,0x11,0x12,0x13,0x10…
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while FULL with data 0xA5A5A5A5.
  - Required response: req_ready=0 and out_data stable for all 3 cycles.
  - Stimulus: out_ready=1 with ch0 valid, data 0x1.
  - Required response: same-edge reload; out_valid stays 1 and out_data becomes 0x1.
- Fixed priority, FIXED_PRIO=1:
  - Stimulus: ch0 and ch1 both continuously valid.
  - Required response: out_ch=0 every cycle. ch1 is granted only in a cycle where ch0 is deasserted.
- Randomised scoreboard:
  - Stimulus: random valid/ready per cycle.
  - Required response: every accepted beat appears exactly once, in acceptance order, with the correct out_ch. No beat is lost or duplicated.
